// File: rtl/pwm_capture.sv
// Input-capture peripheral: measures the period and high (or low) time of a PWM pin
// in prescaled ticks and exposes the results through an 8-bit register window with interrupts.
module pwm_capture #(
    parameter logic [7:0] ADDR_BASE = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       pin_in,
    input  logic       status_reg_interrupt_enable,
    input  logic       interrupt_executed,
    output logic       interrupt_request
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [7:0] OFF_CTRL   = 8'd0;
    localparam logic [7:0] OFF_STATUS = 8'd1;
    localparam logic [7:0] OFF_MASK   = 8'd2;
    localparam logic [7:0] OFF_PER_L  = 8'd3;
    localparam logic [7:0] OFF_PER_H  = 8'd4;
    localparam logic [7:0] OFF_HIGH_L = 8'd5;
    localparam logic [7:0] OFF_HIGH_H = 8'd6;

    state_t      state_q, state_d;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [2:0]  mask_q, mask_d;
    logic [2:0]  flags_q, flags_d;
    logic [15:0] per_q, per_d;
    logic [15:0] highcap_q, highcap_d;
    logic [15:0] hcap_q, hcap_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] shadow_q, shadow_d;
    logic [9:0]  div_q, div_d;
    logic        s1_q, s1_d, s2_q, s2_d;
    logic        irq_q, irq_d;

    logic [7:0]  offset;
    logic        sel, en, inv, tick, p, q, rise, fall;
    logic        cap_set, ov_set, miss_set, intr_exec;
    logic [2:0]  flag_clr;
    logic [15:0] cnt_inc;
    logic        unused_wdata;

    assign offset       = addr - ADDR_BASE;
    assign sel          = (offset < 8'd7);
    assign en           = ctrl_q[0];
    assign inv          = ctrl_q[1];
    assign p            = s1_q ^ inv;
    assign q            = s2_q ^ inv;
    assign rise         = p & ~q;
    assign fall         = ~p & q;
    assign intr_exec    = irq_q & interrupt_executed;
    assign unused_wdata = ^wdata[7:5];
    // Saturating cnt+tick doubles as the captured value so a coincident tick is counted.
    assign cnt_inc      = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + {15'd0, tick};
    assign interrupt_request = irq_q;

    always_comb begin
        case (ctrl_q[4:2])
            3'd1:    tick = 1'b1;
            3'd2:    tick = (div_q[2:0] == 3'd0);
            3'd3:    tick = (div_q[5:0] == 6'd0);
            3'd4:    tick = (div_q[7:0] == 8'd0);
            3'd5:    tick = (div_q[9:0] == 10'd0);
            default: tick = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        mask_d    = mask_q;
        per_d     = per_q;
        highcap_d = highcap_q;
        hcap_d    = hcap_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        div_d     = div_q + 10'd1;
        s1_d      = pin_in;
        s2_d      = s1_q;
        cap_set   = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    cnt_d   = 16'd0;
                    state_d = HIGH;
                end
                HIGH: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hcap_d  = cnt_inc;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    cnt_d = cnt_inc;
                    if (rise) begin
                        per_d     = cnt_inc;
                        highcap_d = hcap_q;
                        cap_set   = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = HIGH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ov_set   = (cnt_q != 16'hFFFF) && (cnt_d == 16'hFFFF);
        miss_set = cap_set & flags_q[0];
        flag_clr = {3{intr_exec}};
        if (write && sel && offset == OFF_STATUS) flag_clr = flag_clr | wdata[2:0];
        // Hardware sets are OR-ed last so they win over any clear in the same cycle.
        flags_d  = (flags_q & ~flag_clr) | {miss_set, ov_set, cap_set};
        irq_d    = (|(flags_q & mask_q)) & status_reg_interrupt_enable & ~intr_exec;

        if (write && sel && offset == OFF_CTRL) ctrl_d = wdata[4:0];
        if (write && sel && offset == OFF_MASK) mask_d = wdata[2:0];
        if (read && sel && offset == OFF_PER_L) shadow_d = {per_q[15:8], highcap_q};
    end

    always_comb begin
        rdata = 8'h00;
        if (read && sel) begin
            case (offset)
                OFF_CTRL:   rdata = {3'b000, ctrl_q};
                OFF_STATUS: rdata = {5'b00000, flags_q};
                OFF_MASK:   rdata = {5'b00000, mask_q};
                OFF_PER_L:  rdata = per_q[7:0];
                OFF_PER_H:  rdata = shadow_q[23:16];
                OFF_HIGH_L: rdata = shadow_q[7:0];
                OFF_HIGH_H: rdata = shadow_q[15:8];
                default:    rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            mask_q    <= '0;
            flags_q   <= '0;
            per_q     <= '0;
            highcap_q <= '0;
            hcap_q    <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            div_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            mask_q    <= mask_d;
            flags_q   <= flags_d;
            per_q     <= per_d;
            highcap_q <= highcap_d;
            hcap_q    <= hcap_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            div_q     <= div_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            irq_q     <= irq_d;
        end
    end
endmodule
